// File: rtl/verset_updown_counter_nch.sv
// NCH independent preset up/down counters with a registered terminal-count pulse.
// Define VERSET_UPDN_CNT_ONESHOT_EN to compile in one-shot halting and the sticky ctr_done flag.
module verset_updown_counter_nch #(
   parameter int WIDTH = 8,
   parameter int NCH   = 4,
   localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 preset_wr,
   input  logic [CHW-1:0]       preset_ch,
   input  logic [WIDTH-1:0]     preset_value,
   input  logic [NCH-1:0]       enable_cnt_up,
   input  logic [NCH-1:0]       enable_cnt_dn,
   input  logic [NCH-1:0]       pause_counting,
   input  logic [NCH-1:0]       one_shot,
   output logic [NCH-1:0]       ctr_expired,
   output logic [NCH-1:0]       ctr_done,
   output logic [NCH*WIDTH-1:0] count_out
);

`ifdef VERSET_UPDN_CNT_ONESHOT_EN
   localparam logic ONESHOT_EN = 1'b1;
`else
   localparam logic ONESHOT_EN = 1'b0;
`endif

   // With the feature compiled out no channel ever halts, so done_reg stays 0.
   logic [NCH-1:0] oneshot_eff;
   assign oneshot_eff = one_shot & {NCH{ONESHOT_EN}};

   generate
      for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
         logic [WIDTH-1:0] preset_reg;
         logic [WIDTH-1:0] count_reg;
         logic [WIDTH-1:0] count_next;
         logic [WIDTH-1:0] eff_preset;
         logic             up_d_reg;
         logic             dn_d_reg;
         logic             expired_reg;
         logic             expired_next;
         logic             done_reg;
         logic             done_next;
         logic             wr_hit;
         logic             rise_up;
         logic             rise_dn;
         logic             hold;

         always_comb begin
            wr_hit       = preset_wr && (preset_ch == CHW'(gi));
            eff_preset   = wr_hit ? preset_value : preset_reg;
            rise_up      = enable_cnt_up[gi] & ~up_d_reg;
            rise_dn      = enable_cnt_dn[gi] & ~dn_d_reg;
            hold         = (enable_cnt_up[gi] && enable_cnt_dn[gi]) || pause_counting[gi] || done_reg;
            count_next   = count_reg;
            expired_next = 1'b0;
            done_next    = done_reg;
            if (rise_dn) begin
               count_next   = eff_preset;
               expired_next = (eff_preset == '0);
            end else if (rise_up) begin
               count_next   = '0;
               expired_next = (eff_preset == '0);
            end else if (!hold) begin
               if (enable_cnt_dn[gi]) begin
                  if (count_reg != '0) begin
                     count_next   = count_reg - WIDTH'(1);
                     expired_next = (count_next == '0);
                  end else if (oneshot_eff[gi]) begin
                     done_next = 1'b1;
                  end else begin
                     count_next   = preset_reg;
                     expired_next = (preset_reg == '0);
                  end
               end else if (enable_cnt_up[gi]) begin
                  if (count_reg != preset_reg) begin
                     count_next   = count_reg + WIDTH'(1);
                     expired_next = (count_next == preset_reg);
                  end else if (oneshot_eff[gi]) begin
                     done_next = 1'b1;
                  end else begin
                     count_next   = '0;
                     expired_next = (preset_reg == '0);
                  end
               end
            end
            // Any restart or reprogramming of the channel re-arms it.
            if (rise_up || rise_dn || wr_hit) begin
               done_next = 1'b0;
            end
         end

         always_ff @(posedge clk) begin
            if (reset) begin
               preset_reg  <= '0;
               count_reg   <= '0;
               up_d_reg    <= 1'b0;
               dn_d_reg    <= 1'b0;
               expired_reg <= 1'b0;
               done_reg    <= 1'b0;
            end else begin
               if (wr_hit) begin
                  preset_reg <= preset_value;
               end
               count_reg   <= count_next;
               up_d_reg    <= enable_cnt_up[gi];
               dn_d_reg    <= enable_cnt_dn[gi];
               expired_reg <= expired_next;
               done_reg    <= done_next;
            end
         end

         assign count_out[gi*WIDTH +: WIDTH] = count_reg;
         assign ctr_expired[gi]              = expired_reg;
`ifdef VERSET_UPDN_CNT_ONESHOT_EN
         assign ctr_done[gi] = done_reg;
`else
         assign ctr_done[gi] = 1'b0;
`endif
      end
   endgenerate

endmodule

// File: tb/tb_verset_updown_counter_nch.sv
// Scoreboard bench for verset_updown_counter_nch (WIDTH=8, NCH=4); expectations
// follow the one-shot build when VERSET_UPDN_CNT_ONESHOT_EN is defined.
module tb_verset_updown_counter_nch;
   localparam int WIDTH = 8;
   localparam int NCH   = 4;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 preset_wr;
   logic [1:0]           preset_ch;
   logic [WIDTH-1:0]     preset_value;
   logic [NCH-1:0]       enable_cnt_up;
   logic [NCH-1:0]       enable_cnt_dn;
   logic [NCH-1:0]       pause_counting;
   logic [NCH-1:0]       one_shot;
   logic [NCH-1:0]       ctr_expired;
   logic [NCH-1:0]       ctr_done;
   logic [NCH*WIDTH-1:0] count_out;

   typedef struct packed {
      logic [3:0]       ch;
      logic [WIDTH-1:0] cnt;
      logic             exp;
      logic             done;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   passed = 0;
   int   cyc    = 0;

   verset_updown_counter_nch #(.WIDTH(WIDTH), .NCH(NCH)) dut (
      .clk            (clk),
      .reset          (reset),
      .preset_wr      (preset_wr),
      .preset_ch      (preset_ch),
      .preset_value   (preset_value),
      .enable_cnt_up  (enable_cnt_up),
      .enable_cnt_dn  (enable_cnt_dn),
      .pause_counting (pause_counting),
      .one_shot       (one_shot),
      .ctr_expired    (ctr_expired),
      .ctr_done       (ctr_done),
      .count_out      (count_out)
   );

   always #5 clk = ~clk;

   // Inputs change on the falling edge; outputs are sampled on the next falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic push(input int ch, input int cnt, input logic exp, input logic done);
      exp_t e;
      e.ch   = 4'(ch);
      e.cnt  = WIDTH'(cnt);
      e.exp  = exp;
      e.done = done;
      sb.push_back(e);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      checks++;
      if (count_out !== '0 || ctr_expired !== '0 || ctr_done !== '0) begin
         $display("FAIL reset cyc %0d: count_out=%h exp=%b done=%b required all zero",
                  cyc, count_out, ctr_expired, ctr_done);
      end else begin
         passed++;
         $display("reset cyc %0d: outputs zero", cyc);
      end
      reset = 1'b0;
   endtask

   task automatic test_down_reload();
      int seq[9] = '{3, 2, 1, 0, 3, 2, 1, 0, 3};
      exp_t e;
      for (int i = 0; i < 10; i++) begin
         preset_wr    = (i == 0);
         preset_ch    = 2'd0;
         preset_value = 8'd3;
         enable_cnt_dn[0] = (i != 0);
         if (i == 0) push(0, 0, 1'b0, 1'b0);
         else        push(0, seq[i-1], seq[i-1] == 0, 1'b0);
         step();
         while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (count_out[e.ch*WIDTH +: WIDTH] !== e.cnt || ctr_expired[e.ch] !== e.exp || ctr_done[e.ch] !== e.done) begin
               $display("FAIL down_reload cyc %0d ch%0d: cnt=%0d exp=%b done=%b required cnt=%0d exp=%b done=%b",
                        cyc, e.ch, count_out[e.ch*WIDTH +: WIDTH], ctr_expired[e.ch], ctr_done[e.ch], e.cnt, e.exp, e.done);
            end else begin
               passed++;
               $display("down_reload cyc %0d ch%0d: cnt=%0d exp=%b", cyc, e.ch, e.cnt, e.exp);
            end
         end
      end
      preset_wr = 1'b0;
   endtask

   task automatic test_pause();
      int   seq[7] = '{3, 3, 3, 2, 1, 0, 0};
      logic xp[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      exp_t e;
      for (int i = 0; i < 7; i++) begin
         pause_counting[0] = (i < 3);
         enable_cnt_dn[0]  = (i != 6);
         push(0, seq[i], xp[i], 1'b0);
         step();
         while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (count_out[e.ch*WIDTH +: WIDTH] !== e.cnt || ctr_expired[e.ch] !== e.exp) begin
               $display("FAIL pause cyc %0d ch%0d: cnt=%0d exp=%b required cnt=%0d exp=%b",
                        cyc, e.ch, count_out[e.ch*WIDTH +: WIDTH], ctr_expired[e.ch], e.cnt, e.exp);
            end else begin
               passed++;
               $display("pause cyc %0d ch%0d: cnt=%0d exp=%b", cyc, e.ch, e.cnt, e.exp);
            end
         end
      end
      pause_counting[0] = 1'b0;
   endtask

   task automatic test_up_reload();
      int seq[10] = '{0, 0, 1, 2, 3, 4, 5, 0, 1, 1};
      exp_t e;
      for (int i = 0; i < 10; i++) begin
         preset_wr        = (i == 0);
         preset_ch        = 2'd1;
         preset_value     = 8'd5;
         enable_cnt_up[1] = (i != 0 && i != 9);
         push(1, seq[i], seq[i] == 5, 1'b0);
         step();
         while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (count_out[e.ch*WIDTH +: WIDTH] !== e.cnt || ctr_expired[e.ch] !== e.exp) begin
               $display("FAIL up_reload cyc %0d ch%0d: cnt=%0d exp=%b required cnt=%0d exp=%b",
                        cyc, e.ch, count_out[e.ch*WIDTH +: WIDTH], ctr_expired[e.ch], e.cnt, e.exp);
            end else begin
               passed++;
               $display("up_reload cyc %0d ch%0d: cnt=%0d exp=%b", cyc, e.ch, e.cnt, e.exp);
            end
         end
      end
      preset_wr = 1'b0;
   endtask

   task automatic test_oneshot();
      logic dn[9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      int   cnt[9];
      logic xp[9];
      logic dn_done[9];
      exp_t e;
`ifdef VERSET_UPDN_CNT_ONESHOT_EN
      cnt     = '{0, 2, 1, 0, 0, 0, 0, 0, 4};
      xp      = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      dn_done = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
`else
      cnt     = '{0, 2, 1, 0, 2, 1, 0, 0, 4};
      xp      = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      dn_done = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
      one_shot[2] = 1'b1;
      for (int i = 0; i < 9; i++) begin
         preset_wr        = (i == 0 || i == 6);
         preset_ch        = 2'd2;
         preset_value     = (i == 0) ? 8'd2 : 8'd4;
         enable_cnt_dn[2] = dn[i];
         push(2, cnt[i], xp[i], dn_done[i]);
         step();
         while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (count_out[e.ch*WIDTH +: WIDTH] !== e.cnt || ctr_expired[e.ch] !== e.exp || ctr_done[e.ch] !== e.done) begin
               $display("FAIL oneshot cyc %0d ch%0d: cnt=%0d exp=%b done=%b required cnt=%0d exp=%b done=%b",
                        cyc, e.ch, count_out[e.ch*WIDTH +: WIDTH], ctr_expired[e.ch], ctr_done[e.ch], e.cnt, e.exp, e.done);
            end else begin
               passed++;
               $display("oneshot cyc %0d ch%0d: cnt=%0d exp=%b done=%b", cyc, e.ch, e.cnt, e.exp, e.done);
            end
         end
      end
      preset_wr        = 1'b0;
      enable_cnt_dn[2] = 1'b0;
      one_shot[2]      = 1'b0;
   endtask

   task automatic test_both_and_reset();
      int   cnt[10] = '{0, 6, 6, 6, 6, 5, 4, 0, 0, 0};
      logic xp[10]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      exp_t e;
      for (int i = 0; i < 10; i++) begin
         preset_wr        = (i == 0);
         preset_ch        = 2'd3;
         preset_value     = 8'd6;
         enable_cnt_dn[3] = (i != 0);
         enable_cnt_up[3] = (i >= 1 && i <= 4);
         reset            = (i == 7);
         if (i == 7) begin
            for (int c = 0; c < NCH; c++) push(c, 0, 1'b0, 1'b0);
         end else begin
            push(3, cnt[i], xp[i], 1'b0);
         end
         step();
         while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (count_out[e.ch*WIDTH +: WIDTH] !== e.cnt || ctr_expired[e.ch] !== e.exp || ctr_done[e.ch] !== e.done) begin
               $display("FAIL both_reset cyc %0d ch%0d: cnt=%0d exp=%b done=%b required cnt=%0d exp=%b done=%b",
                        cyc, e.ch, count_out[e.ch*WIDTH +: WIDTH], ctr_expired[e.ch], ctr_done[e.ch], e.cnt, e.exp, e.done);
            end else begin
               passed++;
               $display("both_reset cyc %0d ch%0d: cnt=%0d exp=%b", cyc, e.ch, e.cnt, e.exp);
            end
         end
      end
      preset_wr        = 1'b0;
      reset            = 1'b0;
      enable_cnt_dn[3] = 1'b0;
      enable_cnt_up[3] = 1'b0;
   endtask

   task automatic test_bypass();
      int cnt[4] = '{0, 7, 6, 6};
      exp_t e;
      for (int i = 0; i < 4; i++) begin
         preset_wr        = (i < 2);
         preset_ch        = 2'd0;
         preset_value     = (i == 0) ? 8'd3 : 8'd7;
         enable_cnt_dn[0] = (i == 1 || i == 2);
         push(0, cnt[i], 1'b0, 1'b0);
         push(1, 0, 1'b0, 1'b0);
         step();
         while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (count_out[e.ch*WIDTH +: WIDTH] !== e.cnt || ctr_expired[e.ch] !== e.exp) begin
               $display("FAIL bypass cyc %0d ch%0d: cnt=%0d exp=%b required cnt=%0d exp=%b",
                        cyc, e.ch, count_out[e.ch*WIDTH +: WIDTH], ctr_expired[e.ch], e.cnt, e.exp);
            end else begin
               passed++;
               $display("bypass cyc %0d ch%0d: cnt=%0d exp=%b", cyc, e.ch, e.cnt, e.exp);
            end
         end
      end
      preset_wr = 1'b0;
   endtask

   initial begin
      reset          = 1'b1;
      preset_wr      = 1'b0;
      preset_ch      = '0;
      preset_value   = '0;
      enable_cnt_up  = '0;
      enable_cnt_dn  = '0;
      pause_counting = '0;
      one_shot       = '0;
      @(negedge clk);
      test_reset();
      test_down_reload();
      test_pause();
      test_up_reload();
      test_oneshot();
      test_both_and_reset();
      test_bypass();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
